// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for the activation/weight FIFOs. A start command
//   pops exactly burst_len words from a FIFO (registered empty, one-cycle
//   read latency) and forwards them to the PE-array loader through a
//   2-entry skid buffer on a valid/ready handshake. The final word carries
//   out_last and done pulses once it has been accepted.
//
// Ports:
//   clk, reset        single clock; synchronous active-low reset
//   start, burst_len  burst request and word count, sampled only in IDLE
//   fifo_empty        FIFO empty flag
//   fifo_rd_en        FIFO pop request (combinational)
//   fifo_data         FIFO read data, valid the cycle after a pop
//   out_data/valid/last, out_ready   downstream valid/ready stream
//   busy              high from the cycle after start until done
//   done              one-cycle pulse after the final word is accepted
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rd_left_q, rd_left_d;
    logic [LEN_W-1:0]  out_left_q, out_left_d;
    logic              in_flight_q, in_flight_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              tail;
    logic [1:0]        occupancy;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf_q[head_q];
    assign out_last  = out_valid && (out_left_q == LEN_W'(1));
    assign busy      = busy_q;
    assign done      = done_q;

    // Buffered plus in-flight words, with the slot freed by this cycle's
    // accept already returned. Counting the freed slot keeps one word per
    // cycle in steady state while still bounding buffer+in-flight to 2.
    always_comb begin
        accept     = out_valid && out_ready;
        occupancy  = count_q + {1'b0, in_flight_q} - {1'b0, accept};
        fifo_rd_en = (state_q == READ) && (rd_left_q != '0) && !fifo_empty
                     && (occupancy < 2'd2);
    end

    // Skid buffer: head drives the output, the returning FIFO word lands at
    // the tail. A push can never meet a full buffer because of the credit
    // check above.
    always_comb begin
        buf_d       = buf_q;
        tail        = head_q ^ count_q[0];
        in_flight_d = fifo_rd_en;
        head_d      = head_q ^ accept;
        count_d     = count_q + {1'b0, in_flight_q} - {1'b0, accept};
        if (in_flight_q) begin
            buf_d[tail] = fifo_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (fifo_rd_en) begin
            rd_left_d = rd_left_q - LEN_W'(1);
        end
        if (accept) begin
            out_left_d = out_left_q - LEN_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_left_d  = burst_len;
                    out_left_d = burst_len;
                    if (burst_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (fifo_rd_en && (rd_left_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && (out_left_q == LEN_W'(1))) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_left_q   <= '0;
            out_left_q  <= '0;
            in_flight_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            head_q      <= 1'b0;
            count_q     <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_left_q   <= rd_left_d;
            out_left_q  <= out_left_d;
            in_flight_q <= in_flight_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
            head_q      <= head_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Bench for fifo_burst_reader. Contains a FIFO model with registered empty
//   and one-cycle read latency, a stream scoreboard (every accepted word must
//   be the next word written into the FIFO, last on the burst_len-th accept,
//   done only after burst_len accepts, held output under back-pressure, at
//   most two words popped but not yet accepted), a cycle table for the
//   nominal 4-word burst, and hand sequences plus random bursts.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [12:0] burst_len = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_q [$];
    int unsigned mon_len = 0;
    int unsigned mon_acc = 0;
    int unsigned mon_pops = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    typedef struct {
        logic       rd;
        logic       vld;
        logic [7:0] data;
        logic       last;
        logic       dn;
        logic       bsy;
    } vec_t;
    vec_t tbl [9];

    fifo_burst_reader #(.DATA_W(8), .LEN_W(13)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // FIFO model: registered empty flag, data valid the cycle after a pop,
    // cleared by the shared reset.
    always @(posedge clk) begin
        if (!reset) begin
            fifo_q.delete();
            exp_q.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= '0;
        end else begin
            if (fifo_rd_en && fifo_q.size() != 0) begin
                fifo_data <= fifo_q.pop_front();
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (fifo_rd_en) begin
                chk("pop_while_empty", fifo_empty, 0);
                mon_pops++;
                chk("pop_within_len", mon_pops <= mon_len, 1);
            end
            if (out_valid && out_ready) begin
                mon_acc++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    chk("out_data_order", out_data, exp_q.pop_front());
                end
                chk("out_last_pos", out_last, mon_acc == mon_len);
            end
            chk("outstanding_le2", (mon_pops - mon_acc) <= 2, 1);
            if (done) begin
                chk("done_after_all", mon_acc, mon_len);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic start_burst(input logic [12:0] len);
        @(posedge clk); #1;
        start     = 1'b1;
        burst_len = len;
        out_ready = 1'b1;
        mon_len   = len;
        mon_acc   = 0;
        mon_pops  = 0;
        @(negedge clk); #1;
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0, other: random ~70%
    task automatic wait_done(input int unsigned npush, input int unsigned push_pct,
                             input int unsigned mode, input string name);
        bit seen;
        int unsigned left;
        seen = 1'b0;
        left = npush;
        for (int unsigned k = 1; k <= 400 && !seen; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 1);
                default: out_ready = ($urandom_range(9) < 7);
            endcase
            if (left != 0 && $urandom_range(99) < push_pct) begin
                push_word(8'($urandom));
                left--;
            end
            @(negedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1);
    endtask

    initial begin
        //            rd    vld   data   last  done  busy
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Nominal 4-word burst, cycle-exact against the table
        @(posedge clk); #1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            start     = (i == 0);
            burst_len = 13'd4;
            out_ready = 1'b1;
            if (i == 0) begin
                mon_len = 4; mon_acc = 0; mon_pops = 0;
            end
            @(negedge clk); #1;
            chk($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].rd);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].data);
            chk($sformatf("tbl%0d_last", i), out_last, tbl[i].last);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
        end
        start = 1'b0;

        // Zero-length burst
        start_burst(13'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_rd_en", fifo_rd_en, 0);
        chk("len0_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("len0_done_once", done, 0);
        chk("len0_valid2", out_valid, 0);

        // 8 words under a 1,0,0 ready pattern
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 8; i++) push_word(8'(8'hA0 + i));
        @(posedge clk); #1;
        start_burst(13'd8);
        wait_done(0, 0, 1, "bp8");
        chk("bp8_all_popped", fifo_q.size(), 0);
        chk("bp8_all_seen", exp_q.size(), 0);

        // FIFO empty for 5 cycles after start, then 3 words arrive
        start_burst(13'd3);
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk); #1;
            chk("empty_no_rd", fifo_rd_en, 0);
            chk("empty_busy", busy, 1);
        end
        wait_done(3, 100, 0, "late3");
        chk("late3_all_seen", exp_q.size(), 0);

        // Reset while the 2nd word of a 6-word burst is on the output
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 6; i++) push_word(8'(8'h60 + i));
        @(posedge clk); #1;
        start_burst(13'd6);
        for (int unsigned k = 0; k < 20 && mon_acc < 1; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk); #1;
        end
        chk("rstmid_first_acc", mon_acc, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_word2_valid", out_valid, 1);
        chk("rstmid_word2_data", out_data, 8'h61);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_last", out_last, 0);
        chk("rstmid_data", out_data, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_rd_en", fifo_rd_en, 0);
        @(posedge clk); #1;
        push_word(8'h5A); push_word(8'hA5);
        @(posedge clk); #1;
        start_burst(13'd2);
        wait_done(0, 0, 0, "after_rst");
        chk("after_rst_all_seen", exp_q.size(), 0);

        // start pulses while busy must be ignored
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 5; i++) push_word(8'(8'hC0 + i));
        @(posedge clk); #1;
        start_burst(13'd3);
        begin
            bit seen;
            seen = 1'b0;
            for (int unsigned k = 1; k <= 40 && !seen; k++) begin
                @(posedge clk); #1;
                start     = (k == 2 || k == 4);
                burst_len = start ? 13'd7 : 13'd3;
                out_ready = 1'b1;
                @(negedge clk); #1;
                if (done) seen = 1'b1;
            end
            chk("busy_start_done_seen", seen, 1);
        end
        chk("busy_start_pops", fifo_q.size(), 2);
        chk("busy_start_acc", mon_acc, 3);
        start_burst(13'd2);
        wait_done(0, 0, 0, "leftover");
        chk("leftover_all_seen", exp_q.size(), 0);

        // Random bursts: random length, sporadic FIFO writes, random ready
        for (int unsigned r = 0; r < 12; r++) begin
            logic [12:0] len;
            len = 13'($urandom_range(1, 24));
            start_burst(len);
            wait_done(len, 60, 2, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_all_seen", r), exp_q.size(), 0);
            chk($sformatf("rnd%0d_fifo_drained", r), fifo_q.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
